// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP MAC sequencer: FSM states, slice opmodes,
// datapath widths and the optional result clamp used when DSP_MAC_SAT_EN is defined.
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int OPND_W = 18;
    localparam int ACC_W  = 48;
    localparam int OPM_W  = 8;

    localparam logic [OPM_W-1:0] OPM_IDLE  = 8'h00;
    localparam logic [OPM_W-1:0] OPM_CLEAR = 8'h01;
    localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;

    localparam logic [ACC_W-1:0] SAT_MAX = 48'h007F_FFFF_FFFF;

    // Clamp an already-wrapped accumulator value to the unsigned 39-bit ceiling.
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W-1:0] p);
        logic [ACC_W-1:0] r;
        if (p > SAT_MAX) begin
            r = SAT_MAX;
        end else begin
            r = p;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_delay_line.sv
// Fixed-depth register delay line with synchronous active-low clear to zero.
// DEPTH of 0 degenerates to a wire.
module dsp_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            // Shift register stages, all cleared on reset.
            always_ff @(posedge i_clk) begin
                if (!i_rstn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences LEN unsigned operand pairs through an external DSP slice and returns
// the 48-bit dot product. Define DSP_MAC_SAT_EN to clamp the result to 39 bits.
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int DSP_LAT = 4,
    parameter int OPM_DLY = 2,
    parameter int LEN_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [OPND_W-1:0] i_in_a,
    input  logic [OPND_W-1:0] i_in_b,
    output logic [OPND_W-1:0] o_dsp_a,
    output logic [OPND_W-1:0] o_dsp_b,
    output logic [OPM_W-1:0]  o_dsp_opmode,
    output logic              o_dsp_ce,
    input  logic [ACC_W-1:0]  i_dsp_p,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [ACC_W-1:0]  o_res_data,
    output logic              o_busy
);

    localparam int DRN_W = (DSP_LAT < 1) ? 1 : $clog2(DSP_LAT + 1);

    state_t              r_state;
    logic [LEN_W-1:0]    r_cnt;
    logic [DRN_W-1:0]    r_drain_cnt;
    logic                r_first;
    logic                r_in_ready;
    logic                r_dsp_ce;
    logic                r_res_valid;
    logic [ACC_W-1:0]    r_res_data;
    logic                r_busy;

    logic                w_accept;
    logic [OPM_W-1:0]    w_opm_src;
    logic [OPND_W-1:0]   w_dsp_a;
    logic [OPND_W-1:0]   w_dsp_b;
    logic [ACC_W-1:0]    w_p_proc;

    assign w_accept = r_in_ready & i_in_valid & (r_state == ST_RUN);

    // Operands go straight to the slice input registers so a pair and its opmode share a cycle.
    always_comb begin
        w_dsp_a = '0;
        w_dsp_b = '0;
        if (w_accept) begin
            w_dsp_a = i_in_a;
            w_dsp_b = i_in_b;
        end else begin
            w_dsp_a = '0;
            w_dsp_b = '0;
        end
    end

    // Opmode source: clear on the first RUN cycle, accumulate after, idle otherwise.
    always_comb begin
        w_opm_src = OPM_IDLE;
        case (r_state)
            ST_RUN:   w_opm_src = r_first ? OPM_CLEAR : OPM_ACC;
            ST_DRAIN: w_opm_src = OPM_ACC;
            default:  w_opm_src = OPM_IDLE;
        endcase
    end

    // Captured-P post-processing: optional clamp, otherwise raw slice output.
    always_comb begin
        w_p_proc = '0;
`ifdef DSP_MAC_SAT_EN
        w_p_proc = sat_clamp(i_dsp_p);
`else
        w_p_proc = i_dsp_p;
`endif
    end

    // Job sequencing FSM with all handshake and control outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_first     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_dsp_ce    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_len != '0) begin
                            r_state    <= ST_RUN;
                            r_cnt      <= i_len;
                            r_first    <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_dsp_ce   <= 1'b1;
                        end else begin
                            r_state     <= ST_HOLD;
                            r_res_data  <= '0;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_first <= 1'b0;
                    if (w_accept) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= DRN_W'(DSP_LAT);
                            r_in_ready  <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Zero operands with accumulate opmode flush the slice pipeline.
                    if (r_drain_cnt == '0) begin
                        r_state     <= ST_HOLD;
                        r_res_data  <= w_p_proc;
                        r_res_valid <= 1'b1;
                        r_dsp_ce    <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRN_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (i_res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_dsp_ce    <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    dsp_delay_line #(
        .WIDTH (OPM_W),
        .DEPTH (OPM_DLY)
    ) u_opm_dly (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (w_opm_src),
        .o_q    (o_dsp_opmode)
    );

    assign o_in_ready  = r_in_ready;
    assign o_dsp_a     = w_dsp_a;
    assign o_dsp_b     = w_dsp_b;
    assign o_dsp_ce    = r_dsp_ce;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP slice (A/B reg, two M stages,
// opmode reg, P reg: four cycles operand-to-P). Honours DSP_MAC_SAT_EN for expectations.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rstn, start, in_valid, in_ready, dsp_ce, res_valid, res_ready, busy;
    logic [7:0]  len_in, dsp_opmode;
    logic [17:0] in_a, in_b, dsp_a, dsp_b;
    logic [47:0] dsp_p, res_data;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .DSP_LAT (4),
        .OPM_DLY (2),
        .LEN_W   (8)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_len        (len_in),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_a       (in_a),
        .i_in_b       (in_b),
        .o_dsp_a      (dsp_a),
        .o_dsp_b      (dsp_b),
        .o_dsp_opmode (dsp_opmode),
        .o_dsp_ce     (dsp_ce),
        .i_dsp_p      (dsp_p),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_data   (res_data),
        .o_busy       (busy)
    );

    // Slice model: opmode bit0 adds M, bit3 adds P; every stage gated by CE.
    logic [17:0] s_a = '0, s_b = '0;
    logic [35:0] s_m1 = '0, s_m2 = '0;
    logic [7:0]  s_opm = '0;
    logic [47:0] s_p = '0;
    always @(posedge clk) begin
        if (dsp_ce) begin
            s_a   <= dsp_a;
            s_b   <= dsp_b;
            s_m1  <= 36'(s_a) * 36'(s_b);
            s_m2  <= s_m1;
            s_opm <= dsp_opmode;
            s_p   <= (s_opm[0] ? {12'd0, s_m2} : 48'd0) + (s_opm[3] ? s_p : 48'd0);
        end
    end
    assign dsp_p = s_p;

    int total = 0;
    int bad   = 0;

    logic [17:0] pa [256];
    logic [17:0] pb [256];

    typedef struct packed {
        logic [7:0]       len;
        logic [7:0]       gap;
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        logic [47:0]      exp;
    } vec_t;

    vec_t vt [5];

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check48(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_res_valid"}, res_valid, 1'b0);
        check48({tag, "_res_data"}, res_data, 48'd0);
        check1({tag, "_in_ready"}, in_ready, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_dsp_ce"}, dsp_ce, 1'b0);
        check48({tag, "_dsp_a"}, 48'(dsp_a), 48'd0);
        check48({tag, "_dsp_b"}, 48'(dsp_b), 48'd0);
        check48({tag, "_opmode"}, 48'(dsp_opmode), 48'd0);
    endtask

    // Reference: plain dot product, wrapped to 48 bits, optionally clamped.
    function automatic logic [47:0] ref_sum(input int n);
        longint unsigned s;
        s = 64'd0;
        for (int i = 0; i < n; i++) begin
            s = s + 64'(pa[i]) * 64'(pb[i]);
        end
        s = s & 64'h0000_FFFF_FFFF_FFFF;
`ifdef DSP_MAC_SAT_EN
        if (s > 64'h0000_007F_FFFF_FFFF) begin
            s = 64'h0000_007F_FFFF_FFFF;
        end
`endif
        return s[47:0];
    endfunction

    task automatic run_job(input int n, input int gap, output logic [47:0] res,
                           output bit rdy_ok, output bit done_ok);
        int w;
        rdy_ok  = 1'b1;
        done_ok = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        len_in = 8'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    if (!in_ready) rdy_ok = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_a     = pa[i];
            in_b     = pb[i];
            w = 0;
            while (!in_ready && w < 20) begin
                rdy_ok = 1'b0;
                @(negedge clk);
                w++;
            end
            if (!in_ready) done_ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        w = 0;
        while (!res_valid && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!res_valid) done_ok = 1'b0;
        res = res_data;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [47:0] res;
        logic [47:0] exp_sat;
        bit          rdy_ok, done_ok, flag;
        int          n, gap;

        vt[0] = '{len: 8'd3, gap: 8'd0, a: {18'd0, 18'd1, 18'd4, 18'd2},
                  b: {18'd0, 18'd1, 18'd5, 18'd3}, exp: 48'd27};
        vt[1] = '{len: 8'd3, gap: 8'd2, a: {18'd0, 18'd1, 18'd4, 18'd2},
                  b: {18'd0, 18'd1, 18'd5, 18'd3}, exp: 48'd27};
        vt[2] = '{len: 8'd1, gap: 8'd0, a: {18'd0, 18'd0, 18'd0, 18'd7},
                  b: {18'd0, 18'd0, 18'd0, 18'd8}, exp: 48'd56};
        vt[3] = '{len: 8'd2, gap: 8'd1, a: {18'd0, 18'd0, 18'd100, 18'h3FFFF},
                  b: {18'd0, 18'd0, 18'd200, 18'd1}, exp: 48'd282143};
        vt[4] = '{len: 8'd4, gap: 8'd0, a: {18'd3, 18'h3FFFF, 18'd5, 18'd0},
                  b: {18'd3, 18'h3FFFF, 18'd0, 18'd5}, exp: 48'd68718952458};

        rstn = 1'b0; start = 1'b0; len_in = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                pa[i] = vt[v].a[i];
                pb[i] = vt[v].b[i];
            end
            run_job(int'(vt[v].len), int'(vt[v].gap), res, rdy_ok, done_ok);
            check48($sformatf("vec%0d_result", v), res, vt[v].exp);
            check1($sformatf("vec%0d_ready_in_run", v), rdy_ok, 1'b1);
            check1($sformatf("vec%0d_completed", v), done_ok, 1'b1);
            check1($sformatf("vec%0d_single_valid", v), res_valid, 1'b0);
            check1($sformatf("vec%0d_idle_after", v), busy, 1'b0);
        end

        // LEN=0: immediate zero result, held against START pulses while RES_READY is low.
        @(negedge clk);
        start = 1'b1; len_in = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check1("len0_valid", res_valid, 1'b1);
        check48("len0_data", res_data, 48'd0);
        check1("len0_busy", busy, 1'b1);
        flag = 1'b1;
        for (int k = 0; k < 10; k++) begin
            start  = (k % 2 == 0);
            len_in = 8'd3;
            @(negedge clk);
            if (!res_valid || res_data != 48'd0 || !busy || in_ready || dsp_ce) flag = 1'b0;
        end
        check1("len0_hold_stable", flag, 1'b1);
        start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; res_ready = 1'b0;
        check1("len0_exit_valid", res_valid, 1'b0);
        check1("len0_exit_start_ignored", busy, 1'b0);
        repeat (2) @(negedge clk);
        check1("len0_no_new_job", busy, 1'b0);

        // Reset partway through a LEN=5 job.
        for (int i = 0; i < 5; i++) begin
            pa[i] = 18'(i + 3);
            pb[i] = 18'(i + 11);
        end
        start = 1'b1; len_in = 8'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
            @(negedge clk);
        end
        check1("midrun_busy", busy, 1'b1);
        check1("midrun_in_ready", in_ready, 1'b1);
        in_valid = 1'b0; in_a = '0; in_b = '0;
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_rst");
        rstn = 1'b1;
        flag = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid || busy) flag = 1'b0;
        end
        check1("midrun_discarded", flag, 1'b1);

        // Long job of maximum operands: clamps only in the saturating build.
        for (int i = 0; i < 255; i++) begin
            pa[i] = 18'h3FFFF;
            pb[i] = 18'h3FFFF;
        end
`ifdef DSP_MAC_SAT_EN
        exp_sat = 48'h007F_FFFF_FFFF;
`else
        exp_sat = 48'd17523332874495;
`endif
        run_job(255, 0, res, rdy_ok, done_ok);
        check48("len255_result", res, exp_sat);
        check1("len255_completed", done_ok, 1'b1);

        // Randomized jobs against the dot-product reference.
        for (int j = 0; j < 8; j++) begin
            n   = int'($urandom_range(1, 8));
            gap = int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                pa[i] = 18'($urandom_range(0, 262143));
                pb[i] = 18'($urandom_range(0, 262143));
            end
            run_job(n, gap, res, rdy_ok, done_ok);
            check48($sformatf("rand%0d_result_len%0d", j, n), res, ref_sum(n));
            check1($sformatf("rand%0d_ready_in_run", j), rdy_ok, 1'b1);
            check1($sformatf("rand%0d_completed", j), done_ok, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
